// File: rtl/display_scanner.sv
// Captures a 16-bit value, converts it to four hex or BCD nibbles, and time-multiplexes
// them onto a single digit bus with active-low one-hot anode enables.
module display_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        mode,
  input  logic        update,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        busy,
  output logic        overflow
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [15:0]   shadow;
  logic          shadow_mode;
  logic [19:0]   bcd;
  logic [19:0]   bcd_adj;
  logic [3:0]    bit_cnt;
  logic [15:0]   disp_reg;
  logic          pending;
  logic [PW-1:0] prescaler;
  logic [1:0]    idx;
  logic [3:0]    lz;

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shadow      <= 16'h0;
      shadow_mode <= 1'b0;
      bcd         <= 20'h0;
      bit_cnt     <= 4'd0;
      disp_reg    <= 16'h0;
      overflow    <= 1'b0;
      pending     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (update) begin
            shadow      <= value;
            shadow_mode <= mode;
            bcd         <= 20'h0;
            bit_cnt     <= 4'd0;
            state       <= mode ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          if (update) begin
            pending <= 1'b1;
          end
          bcd     <= {bcd_adj[18:0], shadow[15]};
          shadow  <= {shadow[14:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) begin
            state <= DONE;
          end
        end
        DONE: begin
          disp_reg <= shadow_mode ? shadow : bcd[15:0];
          overflow <= !shadow_mode && (bcd[19:16] != 4'h0);
          // A strobe landing in this very cycle is serviced together with any queued one.
          if (pending || update) begin
            pending     <= 1'b0;
            shadow      <= value;
            shadow_mode <= mode;
            bcd         <= 20'h0;
            bit_cnt     <= 4'd0;
            state       <= mode ? DONE : SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running refresh prescaler; each wrap advances the scan slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler <= '0;
      idx       <= 2'd0;
    end else if (prescaler == PRE_LAST) begin
      prescaler <= '0;
      idx       <= idx + 2'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  assign busy  = (state != IDLE);
  assign digit = disp_reg[{idx, 2'b00} +: 4];

  // lz[n] means nibble n and every nibble above it is zero; slot 0 is never blanked.
  always_comb begin
    lz[3] = (disp_reg[15:12] == 4'h0);
    lz[2] = lz[3] && (disp_reg[11:8] == 4'h0);
    lz[1] = lz[2] && (disp_reg[7:4] == 4'h0);
    lz[0] = 1'b0;
    an = ~(4'b0001 << idx);
    if (BLANK_LZ && (idx != 2'd0) && lz[idx]) begin
      an = 4'b1111;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: conversion table, reset abort, pending strobe,
// and scan/blanking sequences on a plain and a leading-zero-blanking instance.
module tb_display_scanner;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic        mode;
  logic        update;
  logic [3:0]  digit, an, digit_b, an_b;
  logic        busy, overflow, busy_b, overflow_b;

  int n_vec = 0;
  int n_err = 0;

  display_scanner #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut (
    .clk(clk), .reset(reset), .value(value), .mode(mode), .update(update),
    .digit(digit), .an(an), .busy(busy), .overflow(overflow)
  );

  display_scanner #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut_blank (
    .clk(clk), .reset(reset), .value(value), .mode(mode), .update(update),
    .digit(digit_b), .an(an_b), .busy(busy_b), .overflow(overflow_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic        md;
    logic [15:0] exp_disp;
    logic        exp_ovf;
    int          exp_busy;
  } conv_vec_t;

  conv_vec_t vecs[10];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge so the DUT samples them cleanly on the next rising edge.
  task automatic apply_stimulus(input logic [15:0] v, input logic m);
    @(negedge clk);
    value  = v;
    mode   = m;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  // Align to the start of slot 0 using the unblanked instance, then walk all 16 cycles.
  task automatic check_scan(input string tag, input logic [15:0] exp_disp, input logic [15:0] exp_an_b);
    logic [3:0] prev_an;
    int         tries;
    bit         synced;
    logic [3:0] exp_an [4];
    exp_an[0] = 4'b1110;
    exp_an[1] = 4'b1101;
    exp_an[2] = 4'b1011;
    exp_an[3] = 4'b0111;
    synced = 1'b0;
    tries  = 0;
    while (!synced && tries < 24) begin
      prev_an = an;
      @(negedge clk);
      tries++;
      if (prev_an == 4'b0111 && an == 4'b1110) synced = 1'b1;
    end
    if (!synced) begin
      check_output({tag, "_sync"}, 32'd0, 32'd1);
      return;
    end
    for (int c = 0; c < 16; c++) begin
      check_output($sformatf("%s_digit_c%0d", tag, c), digit, exp_disp[4*(c/4) +: 4]);
      check_output($sformatf("%s_an_c%0d", tag, c), an, exp_an[c/4]);
      check_output($sformatf("%s_digitb_c%0d", tag, c), digit_b, exp_disp[4*(c/4) +: 4]);
      check_output($sformatf("%s_anb_c%0d", tag, c), an_b, exp_an_b[4*(c/4) +: 4]);
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    vecs[0] = '{16'd1234,  1'b0, 16'h1234, 1'b0, 17};
    vecs[1] = '{16'd12345, 1'b0, 16'h2345, 1'b1, 17};
    vecs[2] = '{16'h0001,  1'b1, 16'h0001, 1'b0, 1};
    vecs[3] = '{16'd0,     1'b0, 16'h0000, 1'b0, 17};
    vecs[4] = '{16'd9999,  1'b0, 16'h9999, 1'b0, 17};
    vecs[5] = '{16'd10000, 1'b0, 16'h0000, 1'b1, 17};
    vecs[6] = '{16'hFFFF,  1'b1, 16'hFFFF, 1'b0, 1};
    vecs[7] = '{16'd99,    1'b0, 16'h0099, 1'b0, 17};
    vecs[8] = '{16'hBEEF,  1'b1, 16'hBEEF, 1'b0, 1};
    vecs[9] = '{16'd65535, 1'b0, 16'h5535, 1'b1, 17};

    value  = 16'h0;
    mode   = 1'b0;
    update = 1'b0;
    reset  = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_output("rst_an", an, 4'b1110);
    check_output("rst_digit", digit, 4'h0);
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_overflow", overflow, 1'b0);

    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].val, vecs[i].md);
      count_busy(cnt);
      check_output($sformatf("v%0d_busy_cycles", i), cnt, vecs[i].exp_busy);
      check_output($sformatf("v%0d_disp", i), dut.disp_reg, vecs[i].exp_disp);
      check_output($sformatf("v%0d_overflow", i), overflow, vecs[i].exp_ovf);
    end

    // Reset mid-SHIFT with a pending strobe queued: everything must clear and stay idle.
    apply_stimulus(16'd4321, 1'b0);
    repeat (3) @(negedge clk);
    apply_stimulus(16'hABCD, 1'b1);
    check_output("abort_pending_set", dut.pending, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_output("abort_an", an, 4'b1110);
    check_output("abort_digit", digit, 4'h0);
    check_output("abort_busy", busy, 1'b0);
    check_output("abort_overflow", overflow, 1'b0);
    check_output("abort_pending", dut.pending, 1'b0);
    check_output("abort_disp", dut.disp_reg, 16'h0000);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check_output("abort_stays_idle", cnt, 0);

    // Second strobe during busy cycle 5; its value is sampled at the first DONE.
    apply_stimulus(16'd99, 1'b0);
    repeat (3) @(negedge clk);
    apply_stimulus(16'h00A5, 1'b1);
    repeat (12) @(negedge clk);
    check_output("pend_first_disp", dut.disp_reg, 16'h0099);
    check_output("pend_first_busy", busy, 1'b1);
    @(negedge clk);
    check_output("pend_second_disp", dut.disp_reg, 16'h00A5);
    check_output("pend_second_busy", busy, 1'b0);
    check_output("pend_overflow", overflow, 1'b0);

    apply_stimulus(16'hBEEF, 1'b1);
    count_busy(cnt);
    check_output("beef_busy_cycles", cnt, 1);
    check_scan("beef", 16'hBEEF, 16'h7BDE);

    apply_stimulus(16'd7, 1'b0);
    count_busy(cnt);
    check_output("seven_busy_cycles", cnt, 17);
    check_scan("seven", 16'h0007, 16'hFFFE);

    apply_stimulus(16'd0, 1'b0);
    count_busy(cnt);
    check_scan("zero", 16'h0000, 16'hFFFE);

    apply_stimulus(16'h0305, 1'b1);
    count_busy(cnt);
    check_scan("gap", 16'h0305, 16'hFBDE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
